multicycle_control_unit: RTL and testbench
==========================================

Name: multicycle_control_unit

Overview:
- Parametrised multi-cycle RV32I control unit; next generation of the SW-only sequencer.
- Fetches instructions over the single-port RAM handshake (Cs/We/Ack), decodes LW, SW, ADDI, ADD and SUB, and drives the register-file read ports (rs1/rs2) and write port (rd).
- Adds sign-extended immediates, load write-back, ALU ops, x0 write suppression, a misalignment/illegal-opcode trap and a retire strobe.

Parameters:
- ADDR_WIDTH, 12, RAM byte-address width; PC and data addresses are truncated to this width.
- XLEN, 32, data and instruction width in bits.
- RESET_PC, 0, PC value loaded on reset.

Ports:
- Clk  in  1  clock
- Rst  in  1  synchronous active-high reset
- Addr  out  ADDR_WIDTH  RAM byte address
- Cs  out  1  RAM request; held until Ack
- We  out  1  RAM write enable, qualified by Cs
- Wdata  out  XLEN  RAM write data
- Rdata  in  XLEN  RAM read data, valid when Ack=1
- Ack  in  1  RAM completion; the transfer completes in any cycle with Cs&Ack
- rs1_id  out  5  register-file read port 1 index
- rs1_valid  out  1  read port 1 active
- rs1_data_in  in  XLEN  combinational read data for rs1_id
- rs2_id  out  5  register-file read port 2 index
- rs2_valid  out  1  read port 2 active
- rs2_data_in  in  XLEN  combinational read data for rs2_id
- rd_id  out  5  write-back register index
- rd_valid  out  1  write strobe, one cycle
- rd_data_out  out  XLEN  write-back data
- Pc  out  ADDR_WIDTH  current instruction address
- Retire  out  1  one-cycle pulse on the final cycle of each completed instruction
- Trap  out  1  sticky fault flag

Behaviour:
- Reset: state=RESET, Pc=RESET_PC, instruction register=0, Trap=0. All other outputs are 0 in the RESET state. Rst has priority in every state, including mid-handshake; Cs drops the next cycle.
- States: RESET, FETCH, DECODE, EXEC_SW, EXEC_LW, WRITEBACK, TRAP. Outputs are decoded from the state; only the latched values listed below are registered.
- RESET -> FETCH unconditionally.
- FETCH:
  - Drives Addr=Pc, Cs=1, We=0.
  - On Ack, latches Rdata into the instruction register and goes to DECODE; otherwise stays in FETCH.
- DECODE (1 cycle):
  - Drives rs1_valid=rs2_valid=1, rs1_id=instr[19:15], rs2_id=instr[24:20].
  - Latches the operands and computes the following, all in XLEN bits with wrap-around and no overflow detection:
    - I-imm = sext(instr[31:20])
    - S-imm = sext({instr[31:25],instr[11:7]})
    - eff_addr = rs1 + imm
    - ALU result: ADDI rs1+I-imm; ADD rs1+rs2; SUB rs1-rs2
  - Decode table:
    - 0100011 with funct3=010 (SW) -> EXEC_SW
    - 0000011 with funct3=010 (LW) -> EXEC_LW
    - 0010011 with funct3=000 (ADDI) -> WRITEBACK
    - 0110011 with funct3=000 and funct7=0000000/0100000 (ADD/SUB) -> WRITEBACK
    - anything else -> TRAP
  - LW or SW with eff_addr[1:0]!=0 -> TRAP.
- EXEC_SW:
  - Drives Addr=eff_addr[ADDR_WIDTH-1:0], Cs=1, We=1, Wdata=latched rs2.
  - On Ack: Pc+=4, Retire=1, -> FETCH.
- EXEC_LW:
  - Drives Addr=eff_addr, Cs=1, We=0.
  - On Ack: latches Rdata as the result, -> WRITEBACK.
- WRITEBACK (1 cycle):
  - Drives rd_id=instr[11:7], rd_data_out=result, rd_valid=(rd_id!=0).
  - Pc+=4, Retire=1, -> FETCH.
- TRAP:
  - Trap=1, Cs=0, rd_valid=0; Pc holds the faulting address.
  - Leaves TRAP only on Rst.
- Handshake: Addr/We/Wdata are stable for every cycle Cs=1. Ack with Cs=0 is ignored. Ack in the first request cycle is legal.
- PC wraps modulo 2^ADDR_WIDTH.
- Latency with zero-wait Ack: ALU op 3 cycles (FETCH, DECODE, WB); SW 3 cycles; LW 4 cycles.

Test Plan:
- Reset, then SW x2 -> 8(x1) with x1=0x10, x2=0xDEADBEEF, Ack same-cycle -> write at Addr=0x18 with Wdata=0xDEADBEEF, We=1; Pc=4; Retire once; 3 cycles total.
- LW x3 <- -4(x1) with x1=0x20, RAM[0x1C]=0x12345678, Ack delayed 3 cycles -> Cs held with a stable Addr=0x1C for 4 cycles; then rd_id=3, rd_data_out=0x12345678, rd_valid for 1 cycle.
- ADDI x5, x0, -1 followed by SUB x6, x5, x5 -> rd writes 0xFFFFFFFF then 0x00000000; ADDI x0, x0, 7 -> rd_valid stays 0, Retire still pulses.
- LW with eff_addr=0x22, or opcode 0x7F -> Trap=1, Pc unchanged, no further Cs assertions for 20 cycles.
- Rst asserted during an EXEC_SW wait (Ack=0) -> next cycle Cs=0, Pc=RESET_PC, Trap=0; execution resumes from FETCH at RESET_PC.
- PC at 2^ADDR_WIDTH-4 retiring an ADDI -> Pc wraps to 0.

Source files
------------

// File: rtl/multicycle_control_unit.sv
// rtl/multicycle_control_unit.sv - multi-cycle RV32I subset control unit (LW, SW, ADDI, ADD, SUB)
//
// Ports:
//   Clk, Rst                 clock, synchronous active-high reset
//   Addr/Cs/We/Wdata         single-port RAM request (Cs held until Ack)
//   Rdata/Ack                RAM read data and completion
//   rs1_*/rs2_*              register-file read ports (data returned combinationally)
//   rd_id/rd_valid/rd_data_out  register-file write port
//   Pc                       current instruction address
//   Retire                   one-cycle pulse on the final cycle of each instruction
//   Trap                     sticky fault flag (misaligned access or illegal opcode)
module multicycle_control_unit #(
  parameter int                    ADDR_WIDTH = 12,
  parameter int                    XLEN       = 32,
  parameter logic [ADDR_WIDTH-1:0] RESET_PC   = '0
) (
  input  logic                  Clk,
  input  logic                  Rst,
  output logic [ADDR_WIDTH-1:0] Addr,
  output logic                  Cs,
  output logic                  We,
  output logic [XLEN-1:0]       Wdata,
  input  logic [XLEN-1:0]       Rdata,
  input  logic                  Ack,
  output logic [4:0]            rs1_id,
  output logic                  rs1_valid,
  input  logic [XLEN-1:0]       rs1_data_in,
  output logic [4:0]            rs2_id,
  output logic                  rs2_valid,
  input  logic [XLEN-1:0]       rs2_data_in,
  output logic [4:0]            rd_id,
  output logic                  rd_valid,
  output logic [XLEN-1:0]       rd_data_out,
  output logic [ADDR_WIDTH-1:0] Pc,
  output logic                  Retire,
  output logic                  Trap
);

  typedef enum logic [2:0] {
    S_RESET,
    S_FETCH,
    S_DECODE,
    S_EXEC_SW,
    S_EXEC_LW,
    S_WRITEBACK,
    S_TRAP
  } state_t;

  state_t                  r_state;
  state_t                  w_next_state;
  logic [ADDR_WIDTH-1:0]   r_pc;
  logic [XLEN-1:0]         r_instr;
  logic [ADDR_WIDTH-1:0]   r_eff_addr;
  logic [XLEN-1:0]         r_store_data;
  logic [XLEN-1:0]         r_result;

  logic                    w_pc_inc;
  logic                    w_latch_instr;
  logic                    w_latch_decode;
  logic                    w_latch_load;

  // Instruction field decode
  logic [6:0]              w_opcode;
  logic [2:0]              w_funct3;
  logic [6:0]              w_funct7;
  logic signed [11:0]      w_imm_i12;
  logic signed [11:0]      w_imm_s12;
  logic [XLEN-1:0]         w_imm_i;
  logic [ADDR_WIDTH-1:0]   w_addr_imm;
  logic [ADDR_WIDTH-1:0]   w_eff_addr;
  logic [XLEN-1:0]         w_alu_result;
  logic                    w_is_sw;
  logic                    w_is_lw;
  logic                    w_is_addi;
  logic                    w_is_add;
  logic                    w_is_sub;
  logic                    w_misaligned;

  assign w_opcode  = r_instr[6:0];
  assign w_funct3  = r_instr[14:12];
  assign w_funct7  = r_instr[31:25];
  assign w_imm_i12 = r_instr[31:20];
  assign w_imm_s12 = {r_instr[31:25], r_instr[11:7]};
  assign w_imm_i   = XLEN'(w_imm_i12);

  assign w_is_sw   = (w_opcode == 7'b0100011) && (w_funct3 == 3'b010);
  assign w_is_lw   = (w_opcode == 7'b0000011) && (w_funct3 == 3'b010);
  assign w_is_addi = (w_opcode == 7'b0010011) && (w_funct3 == 3'b000);
  assign w_is_add  = (w_opcode == 7'b0110011) && (w_funct3 == 3'b000) && (w_funct7 == 7'b0000000);
  assign w_is_sub  = (w_opcode == 7'b0110011) && (w_funct3 == 3'b000) && (w_funct7 == 7'b0100000);

  // Only the low ADDR_WIDTH bits of the effective address ever reach the RAM,
  // and the low bits of a sum depend only on the low bits of its operands.
  assign w_addr_imm   = w_is_sw ? ADDR_WIDTH'(w_imm_s12) : ADDR_WIDTH'(w_imm_i12);
  assign w_eff_addr   = rs1_data_in[ADDR_WIDTH-1:0] + w_addr_imm;
  assign w_misaligned = (w_eff_addr[1:0] != 2'b00);

  always_comb begin
    w_alu_result = rs1_data_in + w_imm_i;
    if (w_is_add) w_alu_result = rs1_data_in + rs2_data_in;
    if (w_is_sub) w_alu_result = rs1_data_in - rs2_data_in;
  end

  // State register
  always_ff @(posedge Clk) begin
    if (Rst) r_state <= S_RESET;
    else     r_state <= w_next_state;
  end

  // Next-state and state-decoded outputs
  always_comb begin
    w_next_state   = r_state;
    Addr           = '0;
    Cs             = 1'b0;
    We             = 1'b0;
    Wdata          = '0;
    rs1_id         = 5'd0;
    rs1_valid      = 1'b0;
    rs2_id         = 5'd0;
    rs2_valid      = 1'b0;
    rd_id          = 5'd0;
    rd_valid       = 1'b0;
    rd_data_out    = '0;
    Retire         = 1'b0;
    Trap           = 1'b0;
    w_pc_inc       = 1'b0;
    w_latch_instr  = 1'b0;
    w_latch_decode = 1'b0;
    w_latch_load   = 1'b0;

    case (r_state)
      S_RESET: w_next_state = S_FETCH;

      S_FETCH: begin
        Addr = r_pc;
        Cs   = 1'b1;
        if (Ack) begin
          w_latch_instr = 1'b1;
          w_next_state  = S_DECODE;
        end
      end

      S_DECODE: begin
        rs1_id         = r_instr[19:15];
        rs2_id         = r_instr[24:20];
        rs1_valid      = 1'b1;
        rs2_valid      = 1'b1;
        w_latch_decode = 1'b1;
        if (w_is_sw)                    w_next_state = w_misaligned ? S_TRAP : S_EXEC_SW;
        else if (w_is_lw)               w_next_state = w_misaligned ? S_TRAP : S_EXEC_LW;
        else if (w_is_addi || w_is_add || w_is_sub) w_next_state = S_WRITEBACK;
        else                            w_next_state = S_TRAP;
      end

      S_EXEC_SW: begin
        Addr  = r_eff_addr;
        Cs    = 1'b1;
        We    = 1'b1;
        Wdata = r_store_data;
        if (Ack) begin
          w_pc_inc     = 1'b1;
          Retire       = 1'b1;
          w_next_state = S_FETCH;
        end
      end

      S_EXEC_LW: begin
        Addr = r_eff_addr;
        Cs   = 1'b1;
        if (Ack) begin
          w_latch_load = 1'b1;
          w_next_state = S_WRITEBACK;
        end
      end

      S_WRITEBACK: begin
        rd_id        = r_instr[11:7];
        rd_data_out  = r_result;
        rd_valid     = (r_instr[11:7] != 5'd0);
        w_pc_inc     = 1'b1;
        Retire       = 1'b1;
        w_next_state = S_FETCH;
      end

      S_TRAP: Trap = 1'b1;

      default: w_next_state = S_RESET;
    endcase
  end

  // Datapath registers; Pc is not advanced on a fault so it names the faulting instruction
  always_ff @(posedge Clk) begin
    if (Rst) begin
      r_pc         <= RESET_PC;
      r_instr      <= '0;
      r_eff_addr   <= '0;
      r_store_data <= '0;
      r_result     <= '0;
    end else begin
      if (w_pc_inc)      r_pc <= r_pc + ADDR_WIDTH'(4);
      if (w_latch_instr) r_instr <= Rdata;
      if (w_latch_decode) begin
        r_eff_addr   <= w_eff_addr;
        r_store_data <= rs2_data_in;
        r_result     <= w_alu_result;
      end
      if (w_latch_load)  r_result <= Rdata;
    end
  end

  assign Pc = r_pc;

endmodule

// File: tb/tb_multicycle_control_unit.sv
// tb/tb_multicycle_control_unit.sv - randomized self-checking bench for multicycle_control_unit
module tb_multicycle_control_unit;

  localparam int AW   = 12;
  localparam int XLEN = 32;

  localparam int K_ALU  = 0;
  localparam int K_LW   = 1;
  localparam int K_SW   = 2;
  localparam int K_TRAP = 3;

  logic            Clk = 1'b0;
  logic            Rst = 1'b1;
  logic [AW-1:0]   Addr;
  logic            Cs;
  logic            We;
  logic [XLEN-1:0] Wdata;
  logic [XLEN-1:0] Rdata = '0;
  logic            Ack = 1'b0;
  logic [4:0]      rs1_id;
  logic            rs1_valid;
  logic [XLEN-1:0] rs1_data_in;
  logic [4:0]      rs2_id;
  logic            rs2_valid;
  logic [XLEN-1:0] rs2_data_in;
  logic [4:0]      rd_id;
  logic            rd_valid;
  logic [XLEN-1:0] rd_data_out;
  logic [AW-1:0]   Pc;
  logic            Retire;
  logic            Trap;

  // Architectural state of the reference model; the register array also
  // serves the DUT's combinational read ports.
  logic [31:0] regs [32];
  logic [31:0] mem  [1024];
  logic [AW-1:0] m_pc;

  int n_checks = 0;
  int n_pass   = 0;
  int cyc      = 0;

  always #5 Clk = ~Clk;
  always @(posedge Clk) cyc <= cyc + 1;

  assign rs1_data_in = regs[rs1_id];
  assign rs2_data_in = regs[rs2_id];

  multicycle_control_unit #(.ADDR_WIDTH(AW), .XLEN(XLEN), .RESET_PC('0)) dut (
    .Clk(Clk), .Rst(Rst), .Addr(Addr), .Cs(Cs), .We(We), .Wdata(Wdata),
    .Rdata(Rdata), .Ack(Ack),
    .rs1_id(rs1_id), .rs1_valid(rs1_valid), .rs1_data_in(rs1_data_in),
    .rs2_id(rs2_id), .rs2_valid(rs2_valid), .rs2_data_in(rs2_data_in),
    .rd_id(rd_id), .rd_valid(rd_valid), .rd_data_out(rd_data_out),
    .Pc(Pc), .Retire(Retire), .Trap(Trap)
  );

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h (cycle %0d)", tag, got, exp, cyc);
  endtask

  function automatic logic [31:0] enc_i(input logic [11:0] imm, input logic [4:0] rs1,
                                        input logic [2:0] f3, input logic [4:0] rd, input logic [6:0] op);
    return {imm, rs1, f3, rd, op};
  endfunction

  function automatic logic [31:0] enc_s(input logic [11:0] imm, input logic [4:0] rs2,
                                        input logic [4:0] rs1, input logic [2:0] f3, input logic [6:0] op);
    return {imm[11:5], rs2, rs1, f3, imm[4:0], op};
  endfunction

  function automatic logic [31:0] enc_r(input logic [6:0] f7, input logic [4:0] rs2, input logic [4:0] rs1,
                                        input logic [2:0] f3, input logic [4:0] rd, input logic [6:0] op);
    return {f7, rs2, rs1, f3, rd, op};
  endfunction

  // ISA-level reference: what the instruction does to architectural state.
  function automatic void ref_exec(input logic [31:0] ins, output int kind,
                                   output logic [31:0] val, output logic [31:0] ea);
    logic [31:0] a, b;
    int imm_i, imm_s;
    a = regs[ins[19:15]];
    b = regs[ins[24:20]];
    imm_i = int'(ins[31:20]);
    if (imm_i >= 2048) imm_i -= 4096;
    imm_s = int'({ins[31:25], ins[11:7]});
    if (imm_s >= 2048) imm_s -= 4096;
    kind = K_TRAP;
    val  = '0;
    ea   = '0;
    if (ins[6:0] == 7'h23 && ins[14:12] == 3'd2) begin
      ea   = a + 32'(imm_s);
      val  = b;
      kind = (ea % 4 == 0) ? K_SW : K_TRAP;
    end else if (ins[6:0] == 7'h03 && ins[14:12] == 3'd2) begin
      ea   = a + 32'(imm_i);
      kind = (ea % 4 == 0) ? K_LW : K_TRAP;
    end else if (ins[6:0] == 7'h13 && ins[14:12] == 3'd0) begin
      kind = K_ALU;
      val  = a + 32'(imm_i);
    end else if (ins[6:0] == 7'h33 && ins[14:12] == 3'd0 && ins[31:25] == 7'h00) begin
      kind = K_ALU;
      val  = a + b;
    end else if (ins[6:0] == 7'h33 && ins[14:12] == 3'd0 && ins[31:25] == 7'h20) begin
      kind = K_ALU;
      val  = a - b;
    end
  endfunction

  // Serve one RAM request, acking after dly wait cycles. Entered at a negedge
  // where the request must already be visible; returns one negedge after the Ack cycle.
  task automatic ram_xfer(input string tag, input logic we, input logic [AW-1:0] a,
                          input logic [31:0] wd, input logic [31:0] rdat, input int dly,
                          output logic ret);
    ret = 1'b0;
    for (int c = 0; c <= dly; c++) begin
      check_eq({tag, "_cs"}, 32'(Cs), 32'd1);
      check_eq({tag, "_we"}, 32'(We), 32'(we));
      check_eq({tag, "_addr"}, 32'(Addr), 32'(a));
      if (we) check_eq({tag, "_wdata"}, Wdata, wd);
      check_eq({tag, "_retire_wait"}, 32'(Retire), 32'd0);
      if (c == dly) begin
        Ack   = 1'b1;
        Rdata = rdat;
      end else begin
        Rdata = $urandom;
      end
      #1;
      if (c == dly) ret = Retire;
      @(negedge Clk);
      Ack = 1'b0;
    end
  endtask

  task automatic do_reset();
    Rst = 1'b1;
    Ack = 1'b0;
    @(negedge Clk);
    @(negedge Clk);
    check_eq("rst_cs", 32'(Cs), 32'd0);
    check_eq("rst_we", 32'(We), 32'd0);
    check_eq("rst_addr", 32'(Addr), 32'd0);
    check_eq("rst_pc", 32'(Pc), 32'd0);
    check_eq("rst_trap", 32'(Trap), 32'd0);
    check_eq("rst_retire", 32'(Retire), 32'd0);
    check_eq("rst_rd_valid", 32'(rd_valid), 32'd0);
    check_eq("rst_rs1_valid", 32'(rs1_valid), 32'd0);
    Rst  = 1'b0;
    m_pc = '0;
    @(negedge Clk);
  endtask

  task automatic check_wb(input logic [4:0] rd, input logic [31:0] val);
    check_eq("wb_rd_valid", 32'(rd_valid), 32'(rd != 5'd0));
    check_eq("wb_rd_id", 32'(rd_id), 32'(rd));
    check_eq("wb_rd_data", rd_data_out, val);
    check_eq("wb_retire", 32'(Retire), 32'd1);
    if (rd != 5'd0) regs[rd] = val;
  endtask

  task automatic run_instr(input logic [31:0] ins, input int fdly, input int mdly);
    int kind;
    int c0;
    logic [31:0] val, ea;
    logic ret;
    logic [AW-1:0] pc0;
    pc0 = m_pc;
    c0  = cyc;
    ref_exec(ins, kind, val, ea);
    ram_xfer("fetch", 1'b0, pc0, '0, ins, fdly, ret);
    check_eq("fetch_retire", 32'(ret), 32'd0);
    check_eq("dec_rs1_valid", 32'(rs1_valid), 32'd1);
    check_eq("dec_rs2_valid", 32'(rs2_valid), 32'd1);
    check_eq("dec_rs1_id", 32'(rs1_id), 32'(ins[19:15]));
    check_eq("dec_rs2_id", 32'(rs2_id), 32'(ins[24:20]));
    @(negedge Clk);
    case (kind)
      K_ALU: begin
        check_wb(ins[11:7], val);
        m_pc = m_pc + 12'd4;
        @(negedge Clk);
      end
      K_SW: begin
        ram_xfer("sw", 1'b1, ea[AW-1:0], val, $urandom, mdly, ret);
        check_eq("sw_retire", 32'(ret), 32'd1);
        mem[ea[AW-1:2]] = val;
        m_pc = m_pc + 12'd4;
      end
      K_LW: begin
        ram_xfer("lw", 1'b0, ea[AW-1:0], '0, mem[ea[AW-1:2]], mdly, ret);
        check_eq("lw_ack_retire", 32'(ret), 32'd0);
        check_wb(ins[11:7], mem[ea[AW-1:2]]);
        m_pc = m_pc + 12'd4;
        @(negedge Clk);
      end
      default: begin
        check_eq("trap_flag", 32'(Trap), 32'd1);
        check_eq("trap_pc", 32'(Pc), 32'(pc0));
        check_eq("trap_retire", 32'(Retire), 32'd0);
        check_eq("trap_rd_valid", 32'(rd_valid), 32'd0);
        for (int i = 0; i < 20; i++) begin
          Ack = 1'($urandom_range(0, 1));
          #1;
          check_eq("trap_cs", 32'(Cs), 32'd0);
          check_eq("trap_sticky", 32'(Trap), 32'd1);
          @(negedge Clk);
        end
        check_eq("trap_pc_held", 32'(Pc), 32'(pc0));
        Ack = 1'b0;
        do_reset();
      end
    endcase
    if (kind == K_ALU) check_eq("cycles_alu", 32'(cyc - c0), 32'(fdly + 3));
    if (kind == K_SW)  check_eq("cycles_sw", 32'(cyc - c0), 32'(fdly + mdly + 3));
    if (kind == K_LW)  check_eq("cycles_lw", 32'(cyc - c0), 32'(fdly + mdly + 4));
    check_eq("pc", 32'(Pc), 32'(m_pc));
  endtask

  function automatic logic [31:0] gen_instr(input bit allow_trap);
    logic [4:0]  rd, rs1, rs2;
    logic [11:0] imm;
    logic [1:0]  lo;
    int sel;
    rd  = 5'($urandom);
    rs1 = 5'($urandom);
    rs2 = 5'($urandom);
    imm = 12'($urandom);
    lo  = regs[rs1][1:0];
    sel = allow_trap ? $urandom_range(0, 9) : $urandom_range(0, 7);
    case (sel)
      0, 1: return enc_i(imm, rs1, 3'd0, rd, 7'h13);
      2:    return enc_r(7'h00, rs2, rs1, 3'd0, rd, 7'h33);
      3:    return enc_r(7'h20, rs2, rs1, 3'd0, rd, 7'h33);
      4, 5: begin imm[1:0] = 2'd0 - lo; return enc_i(imm, rs1, 3'd2, rd, 7'h03); end
      6, 7: begin imm[1:0] = 2'd0 - lo; return enc_s(imm, rs2, rs1, 3'd2, 7'h23); end
      8:    return $urandom;
      default: begin imm[1:0] = 2'd1 - lo; return enc_i(imm, rs1, 3'd2, rd, 7'h03); end
    endcase
  endfunction

  initial begin
    logic [31:0] ins;
    logic ret;
    for (int i = 0; i < 32; i++) regs[i] = '0;
    for (int i = 0; i < 1024; i++) mem[i] = $urandom;
    do_reset();

    // SW x2 -> 8(x1), zero-wait
    regs[1] = 32'h10;
    regs[2] = 32'hDEADBEEF;
    run_instr(enc_s(12'd8, 5'd2, 5'd1, 3'd2, 7'h23), 0, 0);

    // LW x3 <- -4(x1), data ack delayed 3 cycles
    regs[1] = 32'h20;
    mem[7]  = 32'h12345678;
    run_instr(enc_i(12'hFFC, 5'd1, 3'd2, 5'd3, 7'h03), 0, 3);

    // ADDI x5,x0,-1 ; SUB x6,x5,x5 ; ADDI x0,x0,7
    run_instr(enc_i(12'hFFF, 5'd0, 3'd0, 5'd5, 7'h13), 0, 0);
    run_instr(enc_r(7'h20, 5'd5, 5'd5, 3'd0, 5'd6, 7'h33), 1, 0);
    run_instr(enc_i(12'd7, 5'd0, 3'd0, 5'd0, 7'h13), 0, 0);

    // Misaligned LW (eff_addr 0x22) and illegal opcode 0x7F
    run_instr(enc_i(12'd2, 5'd1, 3'd2, 5'd7, 7'h03), 0, 0);
    run_instr(32'h0000007F, 2, 0);

    // Reset while EXEC_SW waits on Ack
    ins = enc_s(12'd4, 5'd2, 5'd1, 3'd2, 7'h23);
    ram_xfer("rsw_fetch", 1'b0, m_pc, '0, ins, 0, ret);
    @(negedge Clk);
    check_eq("rsw_cs_pending", 32'(Cs), 32'd1);
    check_eq("rsw_we_pending", 32'(We), 32'd1);
    Rst = 1'b1;
    @(negedge Clk);
    check_eq("rsw_cs_dropped", 32'(Cs), 32'd0);
    check_eq("rsw_pc", 32'(Pc), 32'd0);
    check_eq("rsw_trap", 32'(Trap), 32'd0);
    Rst  = 1'b0;
    m_pc = '0;
    @(negedge Clk);
    check_eq("rsw_refetch_cs", 32'(Cs), 32'd1);
    check_eq("rsw_refetch_addr", 32'(Addr), 32'd0);
    check_eq("rsw_refetch_we", 32'(We), 32'd0);
    ram_xfer("rsw_fetch2", 1'b0, 12'd0, '0, enc_i(12'd1, 5'd0, 3'd0, 5'd9, 7'h13), 0, ret);
    @(negedge Clk);
    check_wb(5'd9, 32'd1);
    m_pc = 12'd4;
    @(negedge Clk);

    // Random legal traffic until Pc reaches the top of the address space
    for (int i = 1; i < 32; i++) regs[i] = $urandom;
    for (int i = 0; i < 2000 && m_pc != 12'hFFC; i++)
      run_instr(gen_instr(1'b0), $urandom_range(0, 3), $urandom_range(0, 3));
    check_eq("wrap_reached", 32'(Pc), 32'hFFC);
    run_instr(enc_i(12'd3, 5'd0, 3'd0, 5'd10, 7'h13), 0, 0);
    check_eq("pc_wrap", 32'(Pc), 32'd0);

    // Random traffic including faults
    for (int i = 0; i < 150; i++)
      run_instr(gen_instr(1'b1), $urandom_range(0, 3), $urandom_range(0, 3));

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  initial begin
    #900000;
    $display("FAIL watchdog: got timeout expected completion");
    $display("%0d/%0d checks passed", n_pass, n_checks + 1);
    $fatal(1);
  end

endmodule
